// File: rtl/store_queue_fwd.sv
// In-order store queue: holds stores until retired, captures late data from
// writeback snoops, forwards to younger loads and drains released stores.
module store_queue_fwd #(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 6,
    parameter int SNOOP_PORTS  = 2,
    parameter int RETIRE_PORTS = 2,
    // Set to 0 where overflow pushes are exercised deliberately.
    parameter bit OVF_ASSERT   = 1'b1,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [31:0]                   i_push_addr,
    input  logic [1:0]                    i_push_size,
    input  logic [BE_W-1:0]               i_push_be,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_push_data_pending,
    input  logic [ID_W-1:0]               i_push_id,
    input  logic [ID_W-1:0]               i_push_id_needed,
    output logic                          o_full,
    output logic                          o_empty,
    input  logic [SNOOP_PORTS-1:0]        i_snoop_valid,
    input  logic [SNOOP_PORTS*ID_W-1:0]   i_snoop_id,
    input  logic [SNOOP_PORTS*DATA_W-1:0] i_snoop_data,
    input  logic [RETIRE_PORTS-1:0]       i_retire_valid,
    input  logic [RETIRE_PORTS*ID_W-1:0]  i_retire_id,
    input  logic                          i_flush,
    input  logic                          i_load_valid,
    input  logic [31:0]                   i_load_addr,
    input  logic [BE_W-1:0]               i_load_be,
    output logic                          o_fwd_hit,
    output logic [DATA_W-1:0]             o_fwd_data,
    output logic                          o_load_conflict,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [31:0]                   o_out_addr,
    output logic [BE_W-1:0]               o_out_be,
    output logic [DATA_W-1:0]             o_out_data,
    output logic [1:0]                    o_out_size,
    output logic                          o_released_pending
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OFS_W = $clog2(BE_W);

    // Spread LSB-justified data across all lanes according to access size.
    function automatic logic [DATA_W-1:0] f_rep(input logic [DATA_W-1:0] d, input logic [1:0] sz);
        logic [DATA_W-1:0] r;
        r = d;
        for (int b = 0; b < BE_W; b++) begin
            case (sz)
                2'd0:    r[b*8 +: 8] = d[7:0];
                2'd1:    r[b*8 +: 8] = d[(b % 2)*8 +: 8];
                2'd2:    r[b*8 +: 8] = d[(b % 4)*8 +: 8];
                default: r[b*8 +: 8] = d[b*8 +: 8];
            endcase
        end
        return r;
    endfunction

    logic [PTR_W-1:0]  r_head, r_tail;
    logic [DEPTH-1:0]  r_valid, r_dv, r_rel;
    logic [ID_W-1:0]   r_id   [DEPTH];
    logic [ID_W-1:0]   r_idn  [DEPTH];
    logic [31:0]       r_addr [DEPTH];
    logic [1:0]        r_size [DEPTH];
    logic [BE_W-1:0]   r_be   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [PTR_W-1:0]  w_count, w_nrel;
    logic [IDX_W-1:0]  w_hslot, w_tslot;
    logic              w_pop, w_push_ok;
    logic [DEPTH-1:0]  w_rel_nxt, w_snp_hit, w_keep;
    logic [DATA_W-1:0] w_snp_dat [DEPTH];
    logic              w_push_snp_hit, w_push_ret;
    logic [DATA_W-1:0] w_push_snp_dat;
    logic              w_order_ok;

    assign w_count   = r_tail - r_head;
    assign w_hslot   = r_head[IDX_W-1:0];
    assign w_tslot   = r_tail[IDX_W-1:0];
    assign o_full    = (w_count == PTR_W'(DEPTH));
    assign o_empty   = (w_count == '0);
    assign w_push_ok = i_push & ~o_full & ~i_flush;

    assign o_out_valid        = r_valid[w_hslot] & r_rel[w_hslot] & r_dv[w_hslot];
    assign w_pop              = o_out_valid & i_out_ready;
    assign o_out_addr         = r_addr[w_hslot];
    assign o_out_be           = r_be[w_hslot];
    assign o_out_data         = r_data[w_hslot];
    assign o_out_size         = r_size[w_hslot];
    assign o_released_pending = |(r_valid & r_rel);

    // Per-entry retire and snoop matches; lowest snoop port wins by scanning downwards.
    always_comb begin
        w_rel_nxt      = r_rel;
        w_snp_hit      = '0;
        w_push_snp_hit = 1'b0;
        w_push_snp_dat = '0;
        w_push_ret     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_snp_dat[i] = '0;
            for (int r = 0; r < RETIRE_PORTS; r++)
                if (i_retire_valid[r] && i_retire_id[r*ID_W +: ID_W] == r_id[i])
                    w_rel_nxt[i] = 1'b1;
            for (int p = SNOOP_PORTS-1; p >= 0; p--)
                if (i_snoop_valid[p] && i_snoop_id[p*ID_W +: ID_W] == r_idn[i]) begin
                    w_snp_hit[i] = 1'b1;
                    w_snp_dat[i] = f_rep(i_snoop_data[p*DATA_W +: DATA_W], r_size[i]);
                end
        end
        for (int r = 0; r < RETIRE_PORTS; r++)
            if (i_retire_valid[r] && i_retire_id[r*ID_W +: ID_W] == i_push_id)
                w_push_ret = 1'b1;
        for (int p = SNOOP_PORTS-1; p >= 0; p--)
            if (i_snoop_valid[p] && i_snoop_id[p*ID_W +: ID_W] == i_push_id_needed) begin
                w_push_snp_hit = 1'b1;
                w_push_snp_dat = f_rep(i_snoop_data[p*DATA_W +: DATA_W], i_push_size);
            end
    end

    // Released prefix from head survives a flush; also check retire ordering.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] s, sp;
        run        = 1'b1;
        w_keep     = '0;
        w_nrel     = '0;
        w_order_ok = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            s = w_hslot + IDX_W'(k);
            if (run && r_valid[s] && r_rel[s]) begin
                w_keep[s] = 1'b1;
                w_nrel    = w_nrel + 1'b1;
            end else begin
                run = 1'b0;
            end
            if (k > 0) begin
                sp = s - 1'b1;
                if (r_valid[s] && w_rel_nxt[s] && r_valid[sp] && !w_rel_nxt[sp])
                    w_order_ok = 1'b0;
            end
        end
    end

    // Forwarding: walk oldest to youngest so the last candidate seen is the youngest.
    always_comb begin
        logic             cand;
        logic [IDX_W-1:0] s, sel;
        cand            = 1'b0;
        sel             = '0;
        o_fwd_hit       = 1'b0;
        o_load_conflict = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            s = w_hslot + IDX_W'(k);
            if (r_valid[s] && (r_addr[s][31:OFS_W] == i_load_addr[31:OFS_W])
                && ((r_be[s] & i_load_be) != '0)) begin
                cand = 1'b1;
                sel  = s;
            end
        end
        o_fwd_data = r_data[sel];
        if (i_load_valid && cand) begin
            if (((r_be[sel] & i_load_be) == i_load_be) && r_dv[sel])
                o_fwd_hit = 1'b1;
            else
                o_load_conflict = 1'b1;
        end
    end

    // Entry state and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_dv    <= '0;
            r_rel   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    r_rel[i] <= w_rel_nxt[i];
                    if (!r_dv[i] && w_snp_hit[i]) begin
                        r_dv[i]   <= 1'b1;
                        r_data[i] <= w_snp_dat[i];
                    end
                end
                if (i_flush && !w_keep[i]) begin
                    r_valid[i] <= 1'b0;
                    r_rel[i]   <= 1'b0;
                end
            end
            if (w_pop)
                r_valid[w_hslot] <= 1'b0;
            if (w_push_ok) begin
                r_valid[w_tslot] <= 1'b1;
                r_rel[w_tslot]   <= w_push_ret;
                r_dv[w_tslot]    <= ~i_push_data_pending | w_push_snp_hit;
                r_data[w_tslot]  <= (i_push_data_pending && w_push_snp_hit) ? w_push_snp_dat
                                                                            : f_rep(i_push_data, i_push_size);
                r_id[w_tslot]    <= i_push_id;
                r_idn[w_tslot]   <= i_push_id_needed;
                r_addr[w_tslot]  <= i_push_addr;
                r_size[w_tslot]  <= i_push_size;
                r_be[w_tslot]    <= i_push_be;
            end
            r_head <= r_head + PTR_W'(w_pop);
            r_tail <= i_flush ? (r_head + w_nrel) : (r_tail + PTR_W'(w_push_ok));
        end
    end

    // Protocol checks: no overflow push, retires keep the released set a head prefix.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (OVF_ASSERT)
                assert (!(i_push && o_full));
            assert (w_order_ok);
        end
    end
endmodule
